// File: rtl/serial_compare_unit_pkg.sv
// Shared definitions for the serial compare unit.
//   cmp_op_e    : 4-bit relational operation codes
//   cmp_state_e : controller states (IDLE, SCAN, DONE)
//   op_is_const : op result does not depend on the operands
//   op_is_signed: op compares operands as two's complement
//   op_result   : final predicate from the scan outcome (eq/lt) and the op
package cmp_pkg;

  typedef enum logic [3:0] {
    OP_EQZ = 4'b0000,  // A == 0
    OP_NEZ = 4'b0001,  // A != 0
    OP_ONE = 4'b0010,  // constant 1
    OP_SGE = 4'b0011,
    OP_SLT = 4'b0100,
    OP_UGE = 4'b0101,
    OP_ULT = 4'b0110,
    OP_EQ  = 4'b0111,
    OP_NE  = 4'b1000,
    OP_SGT = 4'b1001,
    OP_UGT = 4'b1010,
    OP_SLE = 4'b1011,
    OP_ULE = 4'b1100,
    OP_Z13 = 4'b1101,  // constant 0
    OP_Z14 = 4'b1110,  // constant 0
    OP_Z15 = 4'b1111   // constant 0
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  function automatic logic op_is_const(input cmp_op_e op);
    return (op == OP_ONE) || (op == OP_Z13) || (op == OP_Z14) || (op == OP_Z15);
  endfunction

  function automatic logic op_is_signed(input cmp_op_e op);
    return (op == OP_SGE) || (op == OP_SLT) || (op == OP_SGT) || (op == OP_SLE);
  endfunction

  // eq/lt describe A versus B after the scan; signed ops already had their
  // sign bits flipped, so signed and unsigned share the same decode.
  function automatic logic op_result(input logic eq, input logic lt, input cmp_op_e op);
    logic gt;
    logic res;
    gt  = !eq && !lt;
    res = 1'b0;
    case (op)
      OP_EQZ, OP_EQ:          res = eq;
      OP_NEZ, OP_NE:          res = !eq;
      OP_ONE:                 res = 1'b1;
      OP_SGE, OP_UGE:         res = !lt;
      OP_SLT, OP_ULT:         res = lt;
      OP_SGT, OP_UGT:         res = gt;
      OP_SLE, OP_ULE:         res = lt || eq;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_compare_unit_if.sv
// Request/response bundle of the serial compare unit.
//   in_valid/in_ready   : request handshake carrying in1, in2, control
//   out_valid/out_ready : response handshake carrying predicate
//   busy                : a request is in flight
// master = requester/consumer side, slave = compare unit side.
interface serial_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic             predicate;
  logic             busy;

  modport master (
    output in_valid, in1, in2, control, out_ready,
    input  in_ready, out_valid, predicate, busy
  );

  modport slave (
    input  in_valid, in1, in2, control, out_ready,
    output in_ready, out_valid, predicate, busy
  );
endinterface

// File: rtl/serial_compare_unit_chunk_cmp.sv
// Unsigned comparison of one CHUNK-bit slice.
//   a, b : operand slices
//   eq   : a == b
//   lt   : a <  b (unsigned)
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

// File: rtl/serial_compare_unit.sv
// Multi-cycle relational compare unit. Operands are compared CHUNK bits per
// cycle starting at the MSB chunk; with EARLY_EXIT the scan stops at the
// first differing chunk.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_compare_unit_if slave (request in, predicate out)
module serial_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_compare_unit_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_width
      $error("serial_compare_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  cmp_op_e          op_r;
  logic [IDX_W-1:0] idx;
  logic             eq_r;
  logic             lt_r;
  logic             pred_r;

  cmp_op_e          op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             chunk_eq;
  logic             chunk_lt;
  logic             eq_nxt;
  logic             lt_nxt;
  logic             scan_end;

  // Capture-side operand conditioning: zero-tests compare A against 0, and
  // signed ops flip the sign bit so the chunk compare can stay unsigned.
  always_comb begin
    op_in = cmp_op_e'(bus.control);
    a_in  = bus.in1;
    b_in  = ((op_in == OP_EQZ) || (op_in == OP_NEZ)) ? '0 : bus.in2;
    if (op_is_signed(op_in)) begin
      a_in[WIDTH-1] = ~a_in[WIDTH-1];
      b_in[WIDTH-1] = ~b_in[WIDTH-1];
    end
  end

  assign a_sh = a_r >> (CHUNK * int'(idx));
  assign b_sh = b_r >> (CHUNK * int'(idx));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (a_sh[CHUNK-1:0]),
    .b  (b_sh[CHUNK-1:0]),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  // Only the first differing chunk decides lt; once eq_r drops, later
  // chunks (scanned when EARLY_EXIT=0) cannot change the outcome.
  always_comb begin
    eq_nxt   = eq_r && chunk_eq;
    lt_nxt   = (eq_r && !chunk_eq) ? chunk_lt : lt_r;
    scan_end = (idx == '0) || ((EARLY_EXIT != 0) && !chunk_eq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_EQZ;
      idx    <= '0;
      eq_r   <= 1'b0;
      lt_r   <= 1'b0;
      pred_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r  <= a_in;
            b_r  <= b_in;
            op_r <= op_in;
            idx  <= IDX_TOP;
            eq_r <= 1'b1;
            lt_r <= 1'b0;
            if (op_is_const(op_in)) begin
              pred_r <= op_result(1'b1, 1'b0, op_in);
              state  <= ST_DONE;
            end else begin
              state  <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          eq_r <= eq_nxt;
          lt_r <= lt_nxt;
          if (scan_end) begin
            pred_r <= op_result(eq_nxt, lt_nxt, op_r);
            state  <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.predicate = pred_r;

endmodule

// File: tb/tb_serial_compare_unit.sv
// Bench for serial_compare_unit: three instances driven in lockstep
// (32/8 early-exit, 32/8 fixed latency, 32/32 single chunk), checked against
// an arithmetic reference of the predicate and the expected latency.
module tb_serial_compare_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [3:0]  control = '0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_compare_unit_if #(.WIDTH(32)) bus_e ();
  serial_compare_unit_if #(.WIDTH(32)) bus_f ();
  serial_compare_unit_if #(.WIDTH(32)) bus_s ();

  assign bus_e.in_valid = in_valid;  assign bus_f.in_valid = in_valid;  assign bus_s.in_valid = in_valid;
  assign bus_e.in1 = in1;            assign bus_f.in1 = in1;            assign bus_s.in1 = in1;
  assign bus_e.in2 = in2;            assign bus_f.in2 = in2;            assign bus_s.in2 = in2;
  assign bus_e.control = control;    assign bus_f.control = control;    assign bus_s.control = control;
  assign bus_e.out_ready = out_ready; assign bus_f.out_ready = out_ready; assign bus_s.out_ready = out_ready;

  serial_compare_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .bus(bus_e));
  serial_compare_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f));
  serial_compare_unit #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  logic ov[3], pr[3], ir[3], bz[3];
  assign ov[0] = bus_e.out_valid; assign ov[1] = bus_f.out_valid; assign ov[2] = bus_s.out_valid;
  assign pr[0] = bus_e.predicate; assign pr[1] = bus_f.predicate; assign pr[2] = bus_s.predicate;
  assign ir[0] = bus_e.in_ready;  assign ir[1] = bus_f.in_ready;  assign ir[2] = bus_s.in_ready;
  assign bz[0] = bus_e.busy;      assign bz[1] = bus_f.busy;      assign bz[2] = bus_s.busy;

  int nch[3] = '{4, 4, 1};
  int ee[3]  = '{1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_pred(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op);
    case (op)
      4'd0:  return a == 0;
      4'd1:  return a != 0;
      4'd2:  return 1'b1;
      4'd3:  return $signed(a) >= $signed(b);
      4'd4:  return $signed(a) <  $signed(b);
      4'd5:  return a >= b;
      4'd6:  return a <  b;
      4'd7:  return a == b;
      4'd8:  return a != b;
      4'd9:  return $signed(a) >  $signed(b);
      4'd10: return a >  b;
      4'd11: return $signed(a) <= $signed(b);
      4'd12: return a <= b;
      default: return 1'b0;
    endcase
  endfunction

  // Cycle (after the accept edge) at which out_valid is first seen.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op, input int n, input int early);
    logic [31:0] bb;
    int w;
    if (op == 4'd2 || op >= 4'd13) return 1;
    if (!early) return n + 1;
    bb = (op <= 4'd1) ? 32'd0 : b;
    w  = 32 / n;
    for (int i = 0; i < n; i++) begin
      if (((a ^ bb) >> (32 - (i + 1) * w)) != 0) return i + 2;
    end
    return n + 1;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(ir[0] && ir[1] && ir[2]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic done[3];
    logic exp_p;
    done  = '{1'b0, 1'b0, 1'b0};
    exp_p = model_pred(a, b, op);
    wait_idle();
    in1 = a; in2 = b; control = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; control = 4'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!done[d]) begin
          chk($sformatf("busy[%0d] op%0d", d, op), 32'(bz[d]), 32'd1);
          chk($sformatf("in_ready[%0d] op%0d", d, op), 32'(ir[d]), 32'd0);
          if (ov[d]) begin
            chk($sformatf("pred[%0d] op%0d a=%h b=%h", d, op, a, b), 32'(pr[d]), 32'(exp_p));
            chk($sformatf("lat[%0d] op%0d a=%h b=%h", d, op, a, b), 32'(n),
                32'(model_lat(a, b, op, nch[d], ee[d])));
            done[d] = 1'b1;
          end
        end
      end
      if (done[0] && done[1] && done[2]) break;
    end
    for (int d = 0; d < 3; d++)
      if (!done[d]) chk($sformatf("out_valid_timeout[%0d]", d), 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;

    // Reset state
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready[%0d]", d), 32'(ir[d]), 32'd1);
      chk($sformatf("rst_out_valid[%0d]", d), 32'(ov[d]), 32'd0);
      chk($sformatf("rst_pred[%0d]", d), 32'(pr[d]), 32'd0);
      chk($sformatf("rst_busy[%0d]", d), 32'(bz[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run(32'h8000_0000, 32'h0000_0001, 4'b0100);
    run(32'h1234_5678, 32'h1234_5678, 4'b0111);
    run(32'h1234_5678, 32'h1234_5678, 4'b1000);
    run(32'h0000_00FF, 32'h0000_0100, 4'b0110);
    run(32'h0000_00FF, 32'h0000_0100, 4'b1010);
    run(32'h0000_00FF, 32'h0000_0100, 4'b1100);
    run(32'hDEAD_BEEF, 32'h0BAD_F00D, 4'b1111);
    run(32'h0000_0000, 32'hFFFF_FFFF, 4'b0000);
    run(32'h0000_0100, 32'h0000_0000, 4'b0001);
    run(32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b1011);
    run(32'h7FFF_FFFF, 32'h8000_0000, 4'b0011);

    // Backpressure on a constant op
    wait_idle();
    in1 = $urandom; in2 = $urandom; control = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("bp_out_valid[%0d] c%0d", d, n), 32'(ov[d]), 32'd1);
        chk($sformatf("bp_pred[%0d] c%0d", d, n), 32'(pr[d]), 32'd1);
        chk($sformatf("bp_in_ready[%0d] c%0d", d, n), 32'(ir[d]), 32'd0);
        chk($sformatf("bp_busy[%0d] c%0d", d, n), 32'(bz[d]), 32'd1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("bp_release_in_ready[%0d]", d), 32'(ir[d]), 32'd1);
      chk($sformatf("bp_release_out_valid[%0d]", d), 32'(ov[d]), 32'd0);
    end

    // Reset in the middle of a full-length scan
    wait_idle();
    in1 = 32'hCAFE_F00D; in2 = 32'hCAFE_F00D; control = 4'b0111; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid_rst_out_valid[%0d]", d), 32'(ov[d]), 32'd0);
      chk($sformatf("mid_rst_in_ready[%0d]", d), 32'(ir[d]), 32'd1);
      chk($sformatf("mid_rst_busy[%0d]", d), 32'(bz[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk($sformatf("post_rst_out_valid[%0d]", d), 32'(ov[d]), 32'd0);
    end
    run(32'd5, 32'd3, 4'b1001);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      a  = $urandom;
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'd1 << $urandom_range(0, 31));
        3: begin a = (a & 32'hFF) << (8 * $urandom_range(0, 3)); b = $urandom_range(0, 3) << 30; end
        default: b = {a[31:16], 16'($urandom)};
      endcase
      run(a, b, op);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
